// File: rtl/flow_sequencer.sv
// Program-flow controller: owns PC, {T,C,S,Z} status and trap state; sequences fetch/decode.
// Latency: 2 cycles per op with immediate fetch_ack (FETCH, DECODE); trap entry adds 1 cycle.
// Backpressure: holds FETCH until fetch_ack; op_ready drops while alu_trap is high; HALT stalls forever.
module flow_sequencer #(
    parameter int                ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'('h10)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              fetch_req,
    input  logic              fetch_ack,
    output logic [ADDR_W-1:0] pc,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [ADDR_W-1:0] rel_addr,
    input  logic              alu_flags_valid,
    input  logic [2:0]        alu_flags,
    input  logic              alu_trap,
    input  logic [ADDR_W-1:0] gp_in,
    output logic [ADDR_W-1:0] gp_out,
    output logic              gp_we,
    output logic [3:0]        status,
    output logic [ADDR_W-1:0] saved_pc,
    output logic              halted
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_JMP   = 4'd1;
    localparam logic [3:0] OP_JMPZ  = 4'd2;
    localparam logic [3:0] OP_JMPS  = 4'd3;
    localparam logic [3:0] OP_JMPZS = 4'd4;
    localparam logic [3:0] OP_RTT   = 4'd6;
    localparam logic [3:0] OP_LSTAT = 4'd7;
    localparam logic [3:0] OP_XSTAT = 4'd8;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_TRAP   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [3:0]        status_q, status_nxt;
    logic [ADDR_W-1:0] saved_q, saved_nxt;
    logic [ADDR_W-1:0] gp_out_q, gp_out_nxt;
    logic              gp_we_q, gp_we_nxt;
    logic              halted_q, halted_nxt;
    logic              fetch_req_c, op_ready_c;
    logic              xstat_hit;
    logic [ADDR_W-1:0] pc_inc, pc_rel, status_ext;
    logic              flag_z, flag_s, flag_t;

    // Upper GP bits never reach the status register.
    logic gp_in_unused;
    assign gp_in_unused = ^gp_in[ADDR_W-1:4];

    assign pc_inc     = pc_q + ADDR_W'(1);
    assign pc_rel     = pc_q + rel_addr;
    assign status_ext = {{(ADDR_W-4){1'b0}}, status_q};
    assign flag_z     = status_q[0];
    assign flag_s     = status_q[1];
    assign flag_t     = status_q[3];

    // State register; reset aborts any in-flight op and returns to FETCH.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Architectural registers: PC, status, trap return address, GP write port, halt flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            status_q <= 4'h0;
            saved_q  <= '0;
            gp_out_q <= '0;
            gp_we_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_nxt;
            status_q <= status_nxt;
            saved_q  <= saved_nxt;
            gp_out_q <= gp_out_nxt;
            gp_we_q  <= gp_we_nxt;
            halted_q <= halted_nxt;
        end
    end

    // Next-state and op execution; jump conditions read the registered flags, so a
    // same-cycle ALU flag update never affects the branch being retired.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        status_nxt  = status_q;
        saved_nxt   = saved_q;
        gp_out_nxt  = gp_out_q;
        gp_we_nxt   = 1'b0;
        halted_nxt  = halted_q;
        fetch_req_c = 1'b0;
        op_ready_c  = 1'b0;
        xstat_hit   = 1'b0;

        case (state)
            S_FETCH: begin
                fetch_req_c = 1'b1;
                if (fetch_ack) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                op_ready_c = !alu_trap;
                if (alu_trap) begin
                    // ALU exception pre-empts the presented op; PC still points at it.
                    state_nxt = S_TRAP;
                end else if (op_valid) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = pc_inc;
                    case (op_code)
                        OP_NOP: begin
                        end
                        OP_JMP: begin
                            pc_nxt = pc_rel;
                        end
                        OP_JMPZ: begin
                            if (flag_z) pc_nxt = pc_rel;
                        end
                        OP_JMPS: begin
                            if (flag_s) pc_nxt = pc_rel;
                        end
                        OP_JMPZS: begin
                            if (flag_z || flag_s) pc_nxt = pc_rel;
                        end
                        OP_RTT: begin
                            if (flag_t) begin
                                pc_nxt        = saved_q;
                                status_nxt[3] = 1'b0;
                            end else begin
                                state_nxt = S_TRAP;
                                pc_nxt    = pc_q;
                            end
                        end
                        OP_LSTAT: begin
                            gp_out_nxt = status_ext;
                            gp_we_nxt  = 1'b1;
                        end
                        OP_XSTAT: begin
                            xstat_hit       = 1'b1;
                            gp_out_nxt      = status_ext;
                            gp_we_nxt       = 1'b1;
                            status_nxt[2:0] = gp_in[2:0];
                            // T is only writable from inside a trap handler.
                            if (flag_t) status_nxt[3] = gp_in[3];
                        end
                        default: begin
                            // TRAP op and all illegal encodings.
                            state_nxt = S_TRAP;
                            pc_nxt    = pc_q;
                        end
                    endcase
                end
            end
            S_TRAP: begin
                if (!flag_t) begin
                    saved_nxt     = pc_inc;
                    pc_nxt        = TRAP_VECTOR;
                    status_nxt[3] = 1'b1;
                    state_nxt     = S_FETCH;
                end else begin
                    halted_nxt = 1'b1;
                    state_nxt  = S_HALT;
                end
            end
            default: begin
                // S_HALT: everything frozen until reset.
            end
        endcase

        // ALU flags land in any live state; XSTAT owns the flag bits when both collide.
        if (alu_flags_valid && state != S_HALT && !xstat_hit) begin
            status_nxt[2:0] = alu_flags;
        end
    end

    assign fetch_req = fetch_req_c & ~reset;
    assign op_ready  = op_ready_c & ~reset;
    assign pc        = pc_q;
    assign status    = status_q;
    assign saved_pc  = saved_q;
    assign gp_out    = gp_out_q;
    assign gp_we     = gp_we_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_flow_sequencer.sv
// Bench for flow_sequencer: directed scenarios plus random op streams against an instruction-level model.
// Latency: each op is driven as FETCH (optional stall) then DECODE; results are checked once the op retires.
// Backpressure: fetch_ack is withheld for random stall cycles to exercise FETCH hold.
module tb_flow_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req, fetch_ack;
    logic [19:0] pc;
    logic        op_valid, op_ready;
    logic [3:0]  op_code;
    logic [19:0] rel_addr;
    logic        alu_flags_valid;
    logic [2:0]  alu_flags;
    logic        alu_trap;
    logic [19:0] gp_in, gp_out;
    logic        gp_we;
    logic [3:0]  status;
    logic [19:0] saved_pc;
    logic        halted;

    int n_run  = 0;
    int n_fail = 0;

    // Instruction-level model of the architectural state.
    logic [19:0] m_pc, m_saved, m_gp_out;
    logic [3:0]  m_st;
    logic        m_halted, m_we;

    flow_sequencer dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack), .pc(pc),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .rel_addr(rel_addr),
        .alu_flags_valid(alu_flags_valid), .alu_flags(alu_flags), .alu_trap(alu_trap),
        .gp_in(gp_in), .gp_out(gp_out), .gp_we(gp_we),
        .status(status), .saved_pc(saved_pc), .halted(halted)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        reset = 1'b1; fetch_ack = 1'b0; op_valid = 1'b0; alu_trap = 1'b0;
        alu_flags_valid = 1'b0; alu_flags = 3'b0; op_code = 4'd0; rel_addr = '0; gp_in = '0;
        @(negedge clock);
        n_run++;
        if (fetch_req !== 1'b0 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: fetch_req=%b op_ready=%b, expected 0 0", fetch_req, op_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        m_pc = '0; m_saved = '0; m_gp_out = '0; m_st = 4'h0; m_halted = 1'b0; m_we = 1'b0;
        #1;
        n_run++;
        if (pc !== 20'h0 || status !== 4'h0 || saved_pc !== 20'h0 || gp_out !== 20'h0 ||
            gp_we !== 1'b0 || halted !== 1'b0 || fetch_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: pc=%h st=%h sp=%h gpo=%h we=%b h=%b fr=%b, expected 0 0 0 0 0 0 1",
                     pc, status, saved_pc, gp_out, gp_we, halted, fetch_req);
        end
    endtask

    // Drives one op through FETCH/DECODE, updates the model, checks the retired state.
    task automatic run_op(input logic [3:0] code, input logic [19:0] rel, input logic atrap,
                          input logic [19:0] gpv, input int stall,
                          input logic fvf, input logic [2:0] flf,
                          input logic fvd, input logic [2:0] fld);
        logic trap_req, xst;
        n_run++;
        if (fetch_req !== 1'b1 || pc !== m_pc) begin
            n_fail++;
            $display("FAIL fetch_entry: fetch_req=%b pc=%h, expected 1 %h", fetch_req, pc, m_pc);
        end
        for (int i = 0; i < stall; i++) begin
            fetch_ack = 1'b0;
            @(negedge clock);
            n_run++;
            if (fetch_req !== 1'b1 || pc !== m_pc || gp_we !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_stall: fetch_req=%b pc=%h gp_we=%b, expected 1 %h 0",
                         fetch_req, pc, gp_we, m_pc);
            end
        end
        fetch_ack = 1'b1; alu_flags_valid = fvf; alu_flags = flf;
        @(negedge clock);
        if (fvf) m_st[2:0] = flf;
        fetch_ack = 1'b0; alu_flags_valid = fvd; alu_flags = fld;
        op_valid = 1'b1; op_code = code; rel_addr = rel; alu_trap = atrap; gp_in = gpv;
        #1;
        n_run++;
        if (op_ready !== !atrap || fetch_req !== 1'b0 || gp_we !== 1'b0 || pc !== m_pc) begin
            n_fail++;
            $display("FAIL decode: op_ready=%b fetch_req=%b gp_we=%b pc=%h, expected %b 0 0 %h",
                     op_ready, fetch_req, gp_we, pc, !atrap, m_pc);
        end
        @(negedge clock);
        op_valid = 1'b0; alu_trap = 1'b0; alu_flags_valid = 1'b0;

        trap_req = 1'b0; xst = 1'b0; m_we = 1'b0;
        if (atrap) begin
            trap_req = 1'b1;
        end else begin
            case (code)
                4'd0: m_pc = m_pc + 20'd1;
                4'd1: m_pc = m_pc + rel;
                4'd2: m_pc = m_st[0] ? m_pc + rel : m_pc + 20'd1;
                4'd3: m_pc = m_st[1] ? m_pc + rel : m_pc + 20'd1;
                4'd4: m_pc = (m_st[0] | m_st[1]) ? m_pc + rel : m_pc + 20'd1;
                4'd6: begin
                    if (m_st[3]) begin m_pc = m_saved; m_st[3] = 1'b0; end
                    else trap_req = 1'b1;
                end
                4'd7: begin m_gp_out = {16'h0, m_st}; m_we = 1'b1; m_pc = m_pc + 20'd1; end
                4'd8: begin
                    m_gp_out = {16'h0, m_st};
                    m_st[2:0] = gpv[2:0];
                    if (m_st[3]) m_st[3] = gpv[3];
                    m_we = 1'b1; xst = 1'b1; m_pc = m_pc + 20'd1;
                end
                default: trap_req = 1'b1;
            endcase
        end
        if (fvd && !xst) m_st[2:0] = fld;
        if (trap_req) begin
            if (!m_st[3]) begin m_saved = m_pc + 20'd1; m_pc = 20'h10; m_st[3] = 1'b1; end
            else m_halted = 1'b1;
            @(negedge clock);
        end

        n_run++;
        if (pc !== m_pc) begin n_fail++; $display("FAIL op%0d_pc: got %h expected %h", code, pc, m_pc); end
        n_run++;
        if (status !== m_st) begin n_fail++; $display("FAIL op%0d_status: got %h expected %h", code, status, m_st); end
        n_run++;
        if (saved_pc !== m_saved) begin n_fail++; $display("FAIL op%0d_saved_pc: got %h expected %h", code, saved_pc, m_saved); end
        n_run++;
        if (halted !== m_halted) begin n_fail++; $display("FAIL op%0d_halted: got %b expected %b", code, halted, m_halted); end
        n_run++;
        if (gp_we !== m_we) begin n_fail++; $display("FAIL op%0d_gp_we: got %b expected %b", code, gp_we, m_we); end
        n_run++;
        if (gp_out !== m_gp_out) begin n_fail++; $display("FAIL op%0d_gp_out: got %h expected %h", code, gp_out, m_gp_out); end
        n_run++;
        if (fetch_req !== !m_halted) begin n_fail++; $display("FAIL op%0d_fetch_req: got %b expected %b", code, fetch_req, !m_halted); end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_nop();
        apply_reset();
        for (int i = 0; i < 3; i++) run_op(4'd0, 20'h0, 1'b0, 20'h0, i, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== 20'd3 || gp_we !== 1'b0) begin
            n_fail++; $display("FAIL nop_seq: pc=%h gp_we=%b, expected 00003 0", pc, gp_we);
        end
    endtask

    task automatic test_jump();
        run_op(4'd1, 20'd2, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== 20'd5) begin n_fail++; $display("FAIL jmp_fwd: got %h expected 00005", pc); end
        run_op(4'd1, 20'hFFFFD, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== 20'd2) begin n_fail++; $display("FAIL jmp_back: got %h expected 00002", pc); end
        run_op(4'd1, 20'hFFFFD, 1'b0, 20'h0, 1, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== 20'hFFFFF) begin n_fail++; $display("FAIL jmp_to_top: got %h expected fffff", pc); end
        run_op(4'd1, 20'd2, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== 20'd1) begin n_fail++; $display("FAIL jmp_wrap: got %h expected 00001", pc); end
    endtask

    task automatic test_cond();
        logic [19:0] p;
        p = pc;
        run_op(4'd2, 20'd8, 1'b0, 20'h0, 0, 1'b1, 3'b001, 1'b0, 3'b0);
        n_run++;
        if (pc !== p + 20'd8) begin n_fail++; $display("FAIL jmpz_taken: got %h expected %h", pc, p + 20'd8); end
        p = pc;
        run_op(4'd3, 20'd8, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== p + 20'd1) begin n_fail++; $display("FAIL jmps_not_taken: got %h expected %h", pc, p + 20'd1); end
        p = pc;
        run_op(4'd4, 20'd8, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== p + 20'd8) begin n_fail++; $display("FAIL jmpzs_taken: got %h expected %h", pc, p + 20'd8); end
        p = pc;
        run_op(4'd4, 20'd8, 1'b0, 20'h0, 0, 1'b1, 3'b000, 1'b0, 3'b0);
        n_run++;
        if (pc !== p + 20'd1) begin n_fail++; $display("FAIL jmpzs_not_taken: got %h expected %h", pc, p + 20'd1); end
        // A flag update in the decode cycle must not steer the branch it accompanies.
        p = pc;
        run_op(4'd2, 20'd8, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b1, 3'b001);
        n_run++;
        if (pc !== p + 20'd1 || status !== 4'h1) begin
            n_fail++; $display("FAIL flag_order: pc=%h st=%h expected %h 1", pc, status, p + 20'd1);
        end
    endtask

    task automatic test_alu_trap();
        apply_reset();
        run_op(4'd1, 20'd7, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        run_op(4'd1, 20'd100, 1'b1, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== 20'h10 || saved_pc !== 20'd8 || status[3] !== 1'b1) begin
            n_fail++; $display("FAIL alu_trap_entry: pc=%h sp=%h T=%b expected 00010 00008 1", pc, saved_pc, status[3]);
        end
        run_op(4'd6, 20'h0, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (pc !== 20'd8 || status[3] !== 1'b0) begin
            n_fail++; $display("FAIL rtt_return: pc=%h T=%b expected 00008 0", pc, status[3]);
        end
    endtask

    task automatic test_xstat();
        run_op(4'd7, 20'h0, 1'b0, 20'h0, 0, 1'b1, 3'b101, 1'b0, 3'b0);
        n_run++;
        if (gp_out !== 20'h5 || gp_we !== 1'b1) begin
            n_fail++; $display("FAIL lstat: gp_out=%h gp_we=%b expected 00005 1", gp_out, gp_we);
        end
        run_op(4'd8, 20'h0, 1'b0, 20'hF, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (status !== 4'h7 || gp_out !== 20'h5 || gp_we !== 1'b1) begin
            n_fail++; $display("FAIL xstat_user: st=%h gpo=%h we=%b expected 7 00005 1", status, gp_out, gp_we);
        end
        @(negedge clock);
        n_run++;
        if (gp_we !== 1'b0) begin n_fail++; $display("FAIL gp_we_pulse: got %b expected 0", gp_we); end
        run_op(4'd5, 20'h0, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        run_op(4'd8, 20'h0, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        n_run++;
        if (status !== 4'h0 || gp_out !== 20'hF) begin
            n_fail++; $display("FAIL xstat_trap: st=%h gpo=%h expected 0 0000f", status, gp_out);
        end
    endtask

    task automatic test_double_fault();
        logic [3:0] st_frozen;
        run_op(4'd5, 20'h0, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        run_op(4'd5, 20'h0, 1'b0, 20'h0, 0, 1'b0, 3'b0, 1'b0, 3'b0);
        st_frozen = m_st;
        fetch_ack = 1'b1; alu_flags_valid = 1'b1; alu_flags = ~st_frozen[2:0]; op_valid = 1'b1; op_code = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_run++;
            if (halted !== 1'b1 || fetch_req !== 1'b0 || op_ready !== 1'b0 || pc !== m_pc || status !== st_frozen) begin
                n_fail++;
                $display("FAIL halt_hold: h=%b fr=%b or=%b pc=%h st=%h expected 1 0 0 %h %h",
                         halted, fetch_req, op_ready, pc, status, m_pc, st_frozen);
            end
        end
        apply_reset();
        n_run++;
        if (pc !== 20'h0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset: pc=%h halted=%b expected 00000 0", pc, halted);
        end
    endtask

    task automatic test_random();
        logic [3:0] code;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_halted) apply_reset();
            code = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
            run_op(code, 20'($urandom), ($urandom_range(0, 9) == 0), 20'($urandom),
                   $urandom_range(0, 2), 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_jump();
        test_cond();
        test_alu_trap();
        test_xstat();
        test_double_fault();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
